// File: rtl/io_pkg.sv
// Shared types and seven-segment constants for the IO display path.
// Segment bit order is {g,f,e,d,c,b,a}; every pattern is active-low.
package io_pkg;

   typedef enum logic [1:0] {StIdle, StShift, StEncode} state_e;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// One BCD nibble to an active-low seven-segment pattern; non-decimal codes go blank.
module seg7_encode
   import io_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (bcd < 4'd10) seg = SEG_DIGIT[bcd];
   end

endmodule

// File: rtl/bcd_display_driver.sv
// Sequential binary-to-BCD (double dabble) converter feeding DIGITS seven-segment fields.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits above field 0.
module bcd_display_driver
   import io_pkg::*;
#(
   parameter int unsigned IN_W   = 14,
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       value,
   output logic [7*DIGITS-1:0]   display,
   output logic                  ovf,
   output logic                  done
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(IN_W + 1);
   localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;
   localparam logic [7*DIGITS-1:0] DISP_RESET = {DIGITS{SEG_ZERO}};

   state_e                state_q;
   logic [IN_W-1:0]       shreg_q;
   logic [BCD_W-1:0]      bcd_q;
   logic [BCD_W-1:0]      bcd_adj;
   logic [CNT_W-1:0]      cnt_q;
   logic                  ovf_next_q;
   logic [7*DIGITS-1:0]   display_q;
   logic [7*DIGITS-1:0]   display_d;
   logic                  ovf_q;
   logic                  done_q;
   logic [6:0]            seg_pat [DIGITS];
`ifdef LEADING_ZERO_BLANK_EN
   logic                  lead_zero;
`endif

   assign in_ready = (state_q == StIdle) && !rst;
   assign display  = display_q;
   assign ovf      = ovf_q;
   assign done     = done_q;

   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      seg7_encode u_seg7_encode (
         .bcd (bcd_q[4*g +: 4]),
         .seg (seg_pat[g])
      );
   end

   // Overflow replaces every field with a dash regardless of the BCD contents.
   always_comb begin
      display_d = DISP_RESET;
`ifdef LEADING_ZERO_BLANK_EN
      lead_zero = 1'b1;
`endif
      for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
         lead_zero = lead_zero && (bcd_q[4*k +: 4] == 4'd0);
         if (ovf_next_q)                 display_d[7*k +: 7] = SEG_DASH;
         else if (lead_zero && (k != 0)) display_d[7*k +: 7] = SEG_BLANK;
         else                            display_d[7*k +: 7] = seg_pat[k];
`else
         display_d[7*k +: 7] = ovf_next_q ? SEG_DASH : seg_pat[k];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         shreg_q    <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_next_q <= 1'b0;
         display_q  <= DISP_RESET;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  shreg_q    <= value;
                  bcd_q      <= '0;
                  ovf_next_q <= (64'(value) > MAX_VAL);
                  cnt_q      <= CNT_W'(IN_W);
                  state_q    <= StShift;
               end
            end
            StShift: begin
               // Upper carries fall off the top nibble; the ovf path covers those values.
               {bcd_q, shreg_q} <= {bcd_adj, shreg_q} << 1;
               cnt_q            <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_q <= StEncode;
            end
            StEncode: begin
               display_q <= display_d;
               ovf_q     <= ovf_next_q;
               done_q    <= 1'b1;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed self-checking bench for bcd_display_driver (default 14-bit, 4-digit build).
module tb_bcd_display_driver;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'b1111111;
`else
   localparam logic [6:0] LZ = S0;
`endif
   localparam logic [27:0] RST_DISP = {S0, S0, S0, S0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [13:0] value = '0;
   logic [27:0] display;
   logic        ovf;
   logic        done;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int acc_cyc = 0;

   bcd_display_driver #(.IN_W(14), .DIGITS(4)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .value    (value),
      .display  (display),
      .ovf      (ovf),
      .done     (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for in_ready, then presents v for exactly one accepting edge.
   task automatic accept(input logic [13:0] v);
      int n;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL accept_wait: in_ready=%b want 1", in_ready);
      end
      in_valid = 1'b1;
      value    = v;
      tick();
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) begin
            lat = cyc - acc_cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      value = 14'd5;
      tick();
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++; $display("FAIL reset_ready1: got %b want 0", in_ready);
      end
      tick();
      vectors++;
      if (display !== RST_DISP) begin
         miscompares++; $display("FAIL reset_display: got %h want %h", display, RST_DISP);
      end
      vectors++;
      if (ovf !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flags: ovf=%b done=%b ready=%b want 0 0 0", ovf, done, in_ready);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset_ready_after: got %b want 1", in_ready);
      end
   endtask

   task automatic test_convert_1234();
      int lat;
      accept(14'd1234);
      wait_done(lat);
      vectors++;
      if (lat != 15) begin
         miscompares++; $display("FAIL c1234_latency: got %0d want 15", lat);
      end
      vectors++;
      if (display !== {S1, S2, S3, S4} || ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL c1234_display: got %h ovf=%b want %h ovf=0", display, ovf, {S1, S2, S3, S4});
      end
      tick();
      vectors++;
      if (done !== 1'b0) begin
         miscompares++; $display("FAIL c1234_done_width: got %b want 0", done);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int first_acc;
      accept(14'd9999);
      first_acc = acc_cyc;
      wait_done(lat);
      vectors++;
      if (lat != 15 || display !== {S9, S9, S9, S9} || ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_9999: lat=%0d disp=%h ovf=%b want 15 %h 0", lat, display, ovf,
                  {S9, S9, S9, S9});
      end
      accept(14'd10000);
      vectors++;
      if (acc_cyc - first_acc != 16) begin
         miscompares++; $display("FAIL b2b_spacing: got %0d want 16", acc_cyc - first_acc);
      end
      wait_done(lat);
      vectors++;
      if (lat != 15 || display !== {SD, SD, SD, SD} || ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_10000: lat=%0d disp=%h ovf=%b want 15 %h 1", lat, display, ovf,
                  {SD, SD, SD, SD});
      end
   endtask

   task automatic test_busy_ignore();
      int lat;
      int ready_seen;
      accept(14'd42);
      in_valid = 1'b1;
      value = 14'd7777;
      ready_seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (in_ready !== 1'b0) ready_seen++;
         tick();
      end
      vectors++;
      if (ready_seen != 0) begin
         miscompares++; $display("FAIL busy_ready: got %0d ready cycles want 0", ready_seen);
      end
      wait_done(lat);
      vectors++;
      if (lat != 15 || display !== {LZ, LZ, S4, S2} || ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_42: lat=%0d disp=%h ovf=%b want 15 %h 0", lat, display, ovf,
                  {LZ, LZ, S4, S2});
      end
      tick();
      acc_cyc = cyc;
      in_valid = 1'b0;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++; $display("FAIL busy_accept_7777: in_ready=%b want 0", in_ready);
      end
      wait_done(lat);
      vectors++;
      if (lat != 15 || display !== {S7, S7, S7, S7}) begin
         miscompares++;
         $display("FAIL busy_7777: lat=%0d disp=%h want 15 %h", lat, display, {S7, S7, S7, S7});
      end
   endtask

   task automatic test_reset_abort();
      int lat;
      int done_seen;
      accept(14'd5678);
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++; $display("FAIL abort_ready: got %b want 0", in_ready);
      end
      rst = 1'b0;
      vectors++;
      if (display !== RST_DISP || ovf !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_state: disp=%h ovf=%b done=%b want %h 0 0", display, ovf, done,
                  RST_DISP);
      end
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done === 1'b1) done_seen++;
      end
      vectors++;
      if (done_seen != 0) begin
         miscompares++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen);
      end
      accept(14'd5);
      wait_done(lat);
      vectors++;
      if (lat != 15 || display !== {LZ, LZ, LZ, S5} || ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_then_5: lat=%0d disp=%h ovf=%b want 15 %h 0", lat, display, ovf,
                  {LZ, LZ, LZ, S5});
      end
   endtask

   task automatic test_boundaries();
      int lat;
      accept(14'd0);
      wait_done(lat);
      vectors++;
      if (lat != 15 || display !== {LZ, LZ, LZ, S0} || ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL bound_0: lat=%0d disp=%h ovf=%b want 15 %h 0", lat, display, ovf,
                  {LZ, LZ, LZ, S0});
      end
      accept(14'd70);
      wait_done(lat);
      vectors++;
      if (lat != 15 || display !== {LZ, LZ, S7, S0} || ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL bound_70: lat=%0d disp=%h ovf=%b want 15 %h 0", lat, display, ovf,
                  {LZ, LZ, S7, S0});
      end
      accept(14'd16383);
      wait_done(lat);
      vectors++;
      if (lat != 15 || display !== {SD, SD, SD, SD} || ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL bound_16383: lat=%0d disp=%h ovf=%b want 15 %h 1", lat, display, ovf,
                  {SD, SD, SD, SD});
      end
      accept(14'd1000);
      wait_done(lat);
      vectors++;
      if (lat != 15 || display !== {S1, S0, S0, S0} || ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL bound_1000: lat=%0d disp=%h ovf=%b want 15 %h 0", lat, display, ovf,
                  {S1, S0, S0, S0});
      end
   endtask

   initial begin
      test_reset();
      test_convert_1234();
      test_back_to_back();
      test_busy_ignore();
      test_reset_abort();
      test_boundaries();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
